// File: rtl/qpu_exu_wbck_arbiter.sv
// Writeback arbiter: shares the CRF write port between ALU and long-pipe,
// routes measurement results into the MRF and issues OITF/MOITF retire pulses.
module qpu_exu_wbck_arbiter #(
  parameter int XLEN         = 32,
  parameter int RFIDX_W      = 5,
  parameter int QUBIT_NUM    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_wbck_valid,
  output logic                 alu_wbck_ready,
  input  logic [XLEN-1:0]      alu_wbck_data,
  input  logic [RFIDX_W-1:0]   alu_wbck_rdidx,
  input  logic                 lsu_wbck_valid,
  output logic                 lsu_wbck_ready,
  input  logic [XLEN-1:0]      lsu_wbck_data,
  input  logic [RFIDX_W-1:0]   oitf_ret_rdidx,
  input  logic                 oitf_ret_rdwen,
  input  logic                 oitf_empty,
  output logic                 oitf_ret_ena,
  input  logic                 mcu_valid,
  output logic                 mcu_ready,
  input  logic [QUBIT_NUM-1:0] mcu_mask,
  input  logic [QUBIT_NUM-1:0] mcu_result,
  input  logic                 moitf_empty,
  output logic                 moitf_ret_ena,
  output logic                 crf_wbck_ena,
  output logic [RFIDX_W-1:0]   crf_wbck_rdidx,
  output logic [XLEN-1:0]      crf_wbck_data,
  output logic                 mrf_wbck_ena,
  output logic [QUBIT_NUM-1:0] mrf_wbck_mask,
  output logic [QUBIT_NUM-1:0] mrf_wbck_data,
  output logic                 wbck_err
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  logic alu_forced;
  logic lsu_port_need;
  logic alu_hs_p0;
  logic lsu_hs_p0;
  logic lsu_ret_vld_p0;
  logic lsu_wr_vld_p0;
  logic crf_vld_p0;
  logic mrf_vld_p0;
  logic err_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
  endfunction

  // Stage p0: combinational arbitration and handshakes
  always_comb begin
    lsu_port_need  = lsu_wbck_valid & ~oitf_empty & oitf_ret_rdwen;
    alu_forced     = (starve_cnt == CNT_MAX) & alu_wbck_valid;
    lsu_wbck_ready = ~oitf_empty ? ~(lsu_port_need & alu_forced) : 1'b1;
    alu_wbck_ready = ~(lsu_port_need & ~alu_forced);
    mcu_ready      = 1'b1;

    alu_hs_p0      = alu_wbck_valid & alu_wbck_ready;
    lsu_hs_p0      = lsu_wbck_valid & lsu_wbck_ready;
    // A completion arriving with an empty OITF has no entry to retire: drop it
    lsu_ret_vld_p0 = lsu_hs_p0 & ~oitf_empty;
    lsu_wr_vld_p0  = lsu_ret_vld_p0 & oitf_ret_rdwen;
    crf_vld_p0     = lsu_wr_vld_p0 | alu_hs_p0;
    mrf_vld_p0     = mcu_valid & ~moitf_empty;
    err_p0         = (lsu_wbck_valid & oitf_empty) | (mcu_valid & moitf_empty);
  end

  // Stage p1: registered writes, retire pulses and sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt     <= '0;
      crf_wbck_ena   <= 1'b0;
      crf_wbck_rdidx <= '0;
      crf_wbck_data  <= '0;
      oitf_ret_ena   <= 1'b0;
      mrf_wbck_ena   <= 1'b0;
      mrf_wbck_mask  <= '0;
      mrf_wbck_data  <= '0;
      moitf_ret_ena  <= 1'b0;
      wbck_err       <= 1'b0;
    end else begin
      if (alu_wbck_valid & ~alu_wbck_ready)
        starve_cnt <= sat_inc(starve_cnt);
      else
        starve_cnt <= '0;

      crf_wbck_ena <= crf_vld_p0;
      oitf_ret_ena <= lsu_ret_vld_p0;
      if (lsu_wr_vld_p0) begin
        crf_wbck_rdidx <= oitf_ret_rdidx;
        crf_wbck_data  <= lsu_wbck_data;
      end else if (alu_hs_p0) begin
        crf_wbck_rdidx <= alu_wbck_rdidx;
        crf_wbck_data  <= alu_wbck_data;
      end

      mrf_wbck_ena  <= mrf_vld_p0;
      moitf_ret_ena <= mrf_vld_p0;
      if (mrf_vld_p0) begin
        mrf_wbck_mask <= mcu_mask;
        mrf_wbck_data <= mcu_result & mcu_mask;
      end

      wbck_err <= wbck_err | err_p0;
    end
  end

endmodule

// File: tb/tb_qpu_exu_wbck_arbiter.sv
// Directed bench for qpu_exu_wbck_arbiter with hand-computed expectations.
module tb_qpu_exu_wbck_arbiter;

  localparam int XLEN = 32;
  localparam int RFIDX_W = 5;
  localparam int QUBIT_NUM = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 alu_wbck_valid;
  logic                 alu_wbck_ready;
  logic [XLEN-1:0]      alu_wbck_data;
  logic [RFIDX_W-1:0]   alu_wbck_rdidx;
  logic                 lsu_wbck_valid;
  logic                 lsu_wbck_ready;
  logic [XLEN-1:0]      lsu_wbck_data;
  logic [RFIDX_W-1:0]   oitf_ret_rdidx;
  logic                 oitf_ret_rdwen;
  logic                 oitf_empty;
  logic                 oitf_ret_ena;
  logic                 mcu_valid;
  logic                 mcu_ready;
  logic [QUBIT_NUM-1:0] mcu_mask;
  logic [QUBIT_NUM-1:0] mcu_result;
  logic                 moitf_empty;
  logic                 moitf_ret_ena;
  logic                 crf_wbck_ena;
  logic [RFIDX_W-1:0]   crf_wbck_rdidx;
  logic [XLEN-1:0]      crf_wbck_data;
  logic                 mrf_wbck_ena;
  logic [QUBIT_NUM-1:0] mrf_wbck_mask;
  logic [QUBIT_NUM-1:0] mrf_wbck_data;
  logic                 wbck_err;

  int n_checks = 0;
  int n_errs = 0;

  qpu_exu_wbck_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wbck_valid(alu_wbck_valid), .alu_wbck_ready(alu_wbck_ready),
    .alu_wbck_data(alu_wbck_data), .alu_wbck_rdidx(alu_wbck_rdidx),
    .lsu_wbck_valid(lsu_wbck_valid), .lsu_wbck_ready(lsu_wbck_ready),
    .lsu_wbck_data(lsu_wbck_data),
    .oitf_ret_rdidx(oitf_ret_rdidx), .oitf_ret_rdwen(oitf_ret_rdwen),
    .oitf_empty(oitf_empty), .oitf_ret_ena(oitf_ret_ena),
    .mcu_valid(mcu_valid), .mcu_ready(mcu_ready),
    .mcu_mask(mcu_mask), .mcu_result(mcu_result),
    .moitf_empty(moitf_empty), .moitf_ret_ena(moitf_ret_ena),
    .crf_wbck_ena(crf_wbck_ena), .crf_wbck_rdidx(crf_wbck_rdidx),
    .crf_wbck_data(crf_wbck_data),
    .mrf_wbck_ena(mrf_wbck_ena), .mrf_wbck_mask(mrf_wbck_mask),
    .mrf_wbck_data(mrf_wbck_data), .wbck_err(wbck_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    alu_wbck_valid = 1'b0; alu_wbck_data = '0; alu_wbck_rdidx = '0;
    lsu_wbck_valid = 1'b0; lsu_wbck_data = '0;
    oitf_ret_rdidx = '0; oitf_ret_rdwen = 1'b0; oitf_empty = 1'b1;
    mcu_valid = 1'b0; mcu_mask = '0; mcu_result = '0; moitf_empty = 1'b1;
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rst_crf_ena", crf_wbck_ena, 0);
    chk("rst_oitf_ret", oitf_ret_ena, 0);
    chk("rst_mrf_ena", mrf_wbck_ena, 0);
    chk("rst_moitf_ret", moitf_ret_ena, 0);
    chk("rst_err", wbck_err, 0);
    chk("rst_crf_data", crf_wbck_data, 0);
    chk("idle_mcu_ready", mcu_ready, 1);

    // ALU-only writeback
    alu_wbck_valid = 1'b1; alu_wbck_rdidx = 5'd3; alu_wbck_data = 32'h55;
    #1 chk("alu_ready_idle", alu_wbck_ready, 1);
    step();
    alu_wbck_valid = 1'b0;
    chk("alu_wr_ena", crf_wbck_ena, 1);
    chk("alu_wr_idx", crf_wbck_rdidx, 3);
    chk("alu_wr_data", crf_wbck_data, 32'h55);
    step();
    chk("alu_strobe_1cyc", crf_wbck_ena, 0);

    // Long-pipe load beats ALU
    oitf_empty = 1'b0; oitf_ret_rdwen = 1'b1; oitf_ret_rdidx = 5'd7;
    lsu_wbck_valid = 1'b1; lsu_wbck_data = 32'hAA;
    alu_wbck_valid = 1'b1; alu_wbck_rdidx = 5'd4; alu_wbck_data = 32'h44;
    #1;
    chk("ld_alu_ready", alu_wbck_ready, 0);
    chk("ld_lsu_ready", lsu_wbck_ready, 1);
    step();
    lsu_wbck_valid = 1'b0; oitf_empty = 1'b1;
    chk("ld_wr_ena", crf_wbck_ena, 1);
    chk("ld_wr_idx", crf_wbck_rdidx, 7);
    chk("ld_wr_data", crf_wbck_data, 32'hAA);
    chk("ld_oitf_ret", oitf_ret_ena, 1);
    #1 chk("ld_alu_ready_after", alu_wbck_ready, 1);
    step();
    alu_wbck_valid = 1'b0;
    chk("ld_alu_wr_idx", crf_wbck_rdidx, 4);
    chk("ld_alu_wr_data", crf_wbck_data, 32'h44);
    chk("ld_alu_oitf_ret", oitf_ret_ena, 0);
    step();

    // Starvation: two back-to-back windows of 4 stalls then a forced grant
    oitf_empty = 1'b0; oitf_ret_rdwen = 1'b1; oitf_ret_rdidx = 5'd7;
    lsu_wbck_valid = 1'b1;
    alu_wbck_valid = 1'b1; alu_wbck_rdidx = 5'd9; alu_wbck_data = 32'h99;
    for (int i = 0; i < 10; i++) begin
      lsu_wbck_data = 32'h100 + i;
      #1;
      chk($sformatf("stv_alu_ready_%0d", i), alu_wbck_ready, (i % 5) == 4);
      chk($sformatf("stv_lsu_ready_%0d", i), lsu_wbck_ready, (i % 5) != 4);
      step();
      chk($sformatf("stv_wr_ena_%0d", i), crf_wbck_ena, 1);
      chk($sformatf("stv_wr_data_%0d", i), crf_wbck_data,
          ((i % 5) == 4) ? 64'h99 : 64'h100 + 64'(i));
      chk($sformatf("stv_oitf_ret_%0d", i), oitf_ret_ena, (i % 5) != 4);
    end
    lsu_wbck_valid = 1'b0; alu_wbck_valid = 1'b0;
    step();

    // Store completion and ALU write together
    oitf_ret_rdwen = 1'b0; oitf_ret_rdidx = 5'd2;
    lsu_wbck_valid = 1'b1; lsu_wbck_data = 32'hDEAD;
    alu_wbck_valid = 1'b1; alu_wbck_rdidx = 5'd12; alu_wbck_data = 32'h1234;
    #1;
    chk("st_alu_ready", alu_wbck_ready, 1);
    chk("st_lsu_ready", lsu_wbck_ready, 1);
    step();
    lsu_wbck_valid = 1'b0; alu_wbck_valid = 1'b0; oitf_empty = 1'b1;
    chk("st_oitf_ret", oitf_ret_ena, 1);
    chk("st_wr_ena", crf_wbck_ena, 1);
    chk("st_wr_idx", crf_wbck_rdidx, 12);
    chk("st_wr_data", crf_wbck_data, 32'h1234);

    // Measurement writeback
    moitf_empty = 1'b0; mcu_valid = 1'b1; mcu_mask = 8'h0F; mcu_result = 8'hF5;
    #1 chk("mcu_ready", mcu_ready, 1);
    step();
    mcu_valid = 1'b0; moitf_empty = 1'b1;
    chk("mrf_ena", mrf_wbck_ena, 1);
    chk("mrf_mask", mrf_wbck_mask, 8'h0F);
    chk("mrf_data", mrf_wbck_data, 8'h05);
    chk("moitf_ret", moitf_ret_ena, 1);
    chk("mrf_no_err", wbck_err, 0);
    step();
    chk("mrf_strobe_1cyc", mrf_wbck_ena, 0);

    // Measurement with empty MOITF: dropped, sticky error
    mcu_valid = 1'b1; mcu_mask = 8'hFF; mcu_result = 8'h3C;
    #1 chk("mcu_err_ready", mcu_ready, 1);
    step();
    mcu_valid = 1'b0;
    chk("mcu_err_mrf", mrf_wbck_ena, 0);
    chk("mcu_err_ret", moitf_ret_ena, 0);
    chk("mcu_err_flag", wbck_err, 1);
    step(); step();
    chk("err_sticky", wbck_err, 1);

    // Reset while an ALU write is in flight
    rst_n = 1'b0;
    alu_wbck_valid = 1'b1; alu_wbck_rdidx = 5'd1; alu_wbck_data = 32'h77;
    step();
    rst_n = 1'b1; alu_wbck_valid = 1'b0;
    chk("rst2_err", wbck_err, 0);
    chk("rst2_crf_ena", crf_wbck_ena, 0);
    step();
    chk("rst2_no_strobe", crf_wbck_ena, 0);

    // Long-pipe completion with empty OITF
    lsu_wbck_valid = 1'b1; oitf_empty = 1'b1; oitf_ret_rdwen = 1'b1;
    #1 chk("lsu_err_ready", lsu_wbck_ready, 1);
    step();
    lsu_wbck_valid = 1'b0;
    chk("lsu_err_ret", oitf_ret_ena, 0);
    chk("lsu_err_crf", crf_wbck_ena, 0);
    chk("lsu_err_flag", wbck_err, 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/qpu_exu_wbck_arbiter.md
Name: qpu_exu_wbck_arbiter

Overview:
- Shares the single classical register file (CRF) write port between two sources: ALU short-pipe writeback and long-pipe (LSU) writeback.
- Routes measurement results into the measurement result file (MRF).
- Generates the OITF/MOITF retire pulses that free entries in the outstanding-instruction FIFOs.
- Sits between QPU_exu_alu / LSU / measurement unit and the register files. Replaces the static tie-high retire enables used at unit level.

Parameters:
- XLEN, 32, classical data width.
- RFIDX_W, 5, register index width.
- QUBIT_NUM, 8, qubit count (MRF width).
- STARVE_LIMIT, 4, consecutive ALU stall cycles before the ALU is forced a grant.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- alu_wbck_valid  in  1  ALU writeback request
- alu_wbck_ready  out  1  ALU writeback accepted
- alu_wbck_data  in  XLEN  ALU result
- alu_wbck_rdidx  in  RFIDX_W  ALU destination
- lsu_wbck_valid  in  1  long-pipe completion
- lsu_wbck_ready  out  1  long-pipe completion accepted
- lsu_wbck_data  in  XLEN  load data
- oitf_ret_rdidx  in  RFIDX_W  destination of oldest OITF entry
- oitf_ret_rdwen  in  1  oldest OITF entry writes CRF
- oitf_empty  in  1  OITF empty
- oitf_ret_ena  out  1  retire oldest OITF entry
- mcu_valid  in  1  measurement result valid
- mcu_ready  out  1  measurement result accepted
- mcu_mask  in  QUBIT_NUM  qubits measured
- mcu_result  in  QUBIT_NUM  measured values
- moitf_empty  in  1  MOITF empty
- moitf_ret_ena  out  1  retire oldest MOITF entry
- crf_wbck_ena  out  1  CRF write strobe
- crf_wbck_rdidx  out  RFIDX_W  CRF write index
- crf_wbck_data  out  XLEN  CRF write data
- mrf_wbck_ena  out  1  MRF write strobe
- mrf_wbck_mask  out  QUBIT_NUM  MRF bit-enable
- mrf_wbck_data  out  QUBIT_NUM  MRF write data
- wbck_err  out  1  sticky protocol error

Behaviour:
- Reset (rst_n low at a clk edge): all registered outputs 0 (crf_*, mrf_*, oitf_ret_ena, moitf_ret_ena, wbck_err); starvation counter = 0. Reset mid-transfer discards the registered write; no strobe is emitted in the cycle following reset.
- Handshakes are combinational: a transfer occurs when valid & ready are both high in the same cycle. Register-file writes and retire pulses are registered, 1-cycle latency after the handshake, with one-cycle strobes.

Classical arbitration (grant computed combinationally each cycle):
- lsu_port_need = lsu_wbck_valid & ~oitf_empty & oitf_ret_rdwen.
- Default priority: long-pipe over ALU.
- Starvation override: if starve_cnt == STARVE_LIMIT and alu_wbck_valid, the ALU wins and the long-pipe waits.
- lsu_wbck_ready = ~oitf_empty ? ~(lsu_port_need & alu_forced) : 1.
- alu_wbck_ready = ~(lsu_port_need & ~alu_forced).
- Long-pipe completion with oitf_ret_rdwen=0 (store) does not use the port:
  - it retires (oitf_ret_ena pulses) with no CRF write;
  - the ALU may write in the same cycle.
- Long-pipe handshake with ~oitf_empty:
  - next cycle oitf_ret_ena=1;
  - if rdwen, crf_wbck_ena=1, rdidx=oitf_ret_rdidx, data=lsu_wbck_data.
- ALU handshake: next cycle crf_wbck_ena=1, rdidx/data from the ALU.
- Both handshakes in the same cycle are possible only when the LSU has rdwen=0.

Starvation counter (saturating, 0..STARVE_LIMIT):
- Increments when alu_wbck_valid & ~alu_wbck_ready.
- Clears on an ALU handshake or when alu_wbck_valid is low.
- Saturates at STARVE_LIMIT.

Measurement path (independent of the CRF path):
- mcu_ready = 1 always.
- Handshake with ~moitf_empty: next cycle mrf_wbck_ena=1, mrf_wbck_mask=mcu_mask, mrf_wbck_data=mcu_result & mcu_mask, moitf_ret_ena=1.

Protocol errors:
- lsu_wbck_valid while oitf_empty: accepted (ready=1), dropped (no retire, no write), wbck_err set.
- mcu_valid while moitf_empty: accepted, dropped, wbck_err set.
- wbck_err is sticky until reset.

Throughput: one CRF write, one OITF retire and one MOITF retire per cycle maximum, all concurrent.

Test Plan:
- Reset then idle: all outputs 0; ALU valid with rdidx=3, data=0x55 -> next cycle crf_wbck_ena=1, rdidx=3, data=0x55, alu_wbck_ready was 1.
- OITF non-empty, rdwen=1, rdidx=7, LSU data=0xAA, ALU valid same cycle -> alu_wbck_ready=0; next cycle CRF writes r7=0xAA and oitf_ret_ena=1; ALU writes the following cycle.
- LSU valid with rdwen=1 every cycle for 6 cycles while ALU valid -> ALU stalls 4 cycles, is granted on the 5th (lsu_wbck_ready=0 that cycle); counter returns to 0.
- LSU store completion (rdwen=0) and ALU valid together -> both ready=1; next cycle oitf_ret_ena=1 and CRF write carries the ALU rdidx/data.
- MOITF non-empty, mcu_mask=0x0F, mcu_result=0xF5 -> next cycle mrf_wbck_ena=1, mask=0x0F, data=0x05, moitf_ret_ena=1.
- mcu_valid with moitf_empty=1 -> no MRF write, no retire, wbck_err=1 and stays 1 until rst_n low at a clk edge.
